// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one combinational alu between an execute-stage
// requester (port A) and a branch-compare requester (port B). Round-robin
// arbitration, one-entry registered response buffer with valid/ready
// backpressure, and per-port saturating grant counters for debug.
// Only DATA_W = 32 matches the attached alu.
module alu_share_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TAG_W  = 2,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  // port A: execute stage
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [2:0]        a_op_select,
  input  logic [DATA_W-1:0] a_op1,
  input  logic [DATA_W-1:0] a_op2,
  input  logic              a_alt_operator,
  input  logic              a_branch_mode,
  input  logic [TAG_W-1:0]  a_tag,
  // port B: branch-compare unit
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [2:0]        b_op_select,
  input  logic [DATA_W-1:0] b_op1,
  input  logic [DATA_W-1:0] b_op2,
  input  logic              b_alt_operator,
  input  logic              b_branch_mode,
  input  logic [TAG_W-1:0]  b_tag,
  // shared alu
  output logic [2:0]        alu_op_select,
  output logic [DATA_W-1:0] alu_op1,
  output logic [DATA_W-1:0] alu_op2,
  output logic              alu_alt_operator,
  output logic              alu_branch_mode,
  input  logic [DATA_W-1:0] alu_result,
  // response buffer
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_src,
  output logic [TAG_W-1:0]  rsp_tag,
  // debug counters
  output logic [CNT_W-1:0]  cnt_a,
  output logic [CNT_W-1:0]  cnt_b
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic                last_grant_q, last_grant_d;
  logic [DATA_W-1:0]   rsp_result_q, rsp_result_d;
  logic                rsp_src_q, rsp_src_d;
  logic [TAG_W-1:0]    rsp_tag_q, rsp_tag_d;
  logic [CNT_W-1:0]    cnt_a_q, cnt_a_d;
  logic [CNT_W-1:0]    cnt_b_q, cnt_b_d;

  logic                slot_free;
  logic                grant_a;
  logic                grant_b;

  // Round-robin grant; the loser of the last contention wins the next one.
  // Gated by rst_n so no ready escapes while reset is held.
  always_comb begin
    slot_free = (state_q == EMPTY) | rsp_ready;
    grant_a   = rst_n & slot_free & a_valid & (~b_valid | last_grant_q);
    grant_b   = rst_n & slot_free & b_valid & (~a_valid | ~last_grant_q);
  end

  assign a_ready = grant_a;
  assign b_ready = grant_b;

  // Steer the granted request onto the alu; zeros when idle.
  always_comb begin
    alu_op_select    = 3'b000;
    alu_op1          = '0;
    alu_op2          = '0;
    alu_alt_operator = 1'b0;
    alu_branch_mode  = 1'b0;
    if (grant_a) begin
      alu_op_select    = a_op_select;
      alu_op1          = a_op1;
      alu_op2          = a_op2;
      alu_alt_operator = a_alt_operator;
      alu_branch_mode  = a_branch_mode;
    end else if (grant_b) begin
      alu_op_select    = b_op_select;
      alu_op1          = b_op1;
      alu_op2          = b_op2;
      alu_alt_operator = b_alt_operator;
      alu_branch_mode  = b_branch_mode;
    end
  end

  // Next-state and buffer update; a grant in FULL overwrites while draining.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    rsp_result_d = rsp_result_q;
    rsp_src_d    = rsp_src_q;
    rsp_tag_d    = rsp_tag_q;
    cnt_a_d      = cnt_a_q;
    cnt_b_d      = cnt_b_q;

    unique case (state_q)
      EMPTY: begin
        if (grant_a || grant_b) begin
          state_d = FULL;
        end
      end
      FULL: begin
        if (!(grant_a || grant_b) && rsp_ready) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase

    if (grant_a || grant_b) begin
      rsp_result_d = alu_result;
      rsp_src_d    = grant_b;
      rsp_tag_d    = grant_b ? b_tag : a_tag;
      last_grant_d = grant_b;
    end

    if (grant_a && (cnt_a_q != CNT_MAX)) begin
      cnt_a_d = cnt_a_q + CNT_W'(1);
    end
    if (grant_b && (cnt_b_q != CNT_MAX)) begin
      cnt_b_d = cnt_b_q + CNT_W'(1);
    end
  end

  // State, response buffer and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= EMPTY;
      last_grant_q <= 1'b1;
      rsp_result_q <= '0;
      rsp_src_q    <= 1'b0;
      rsp_tag_q    <= '0;
      cnt_a_q      <= '0;
      cnt_b_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      rsp_result_q <= rsp_result_d;
      rsp_src_q    <= rsp_src_d;
      rsp_tag_q    <= rsp_tag_d;
      cnt_a_q      <= cnt_a_d;
      cnt_b_q      <= cnt_b_d;
    end
  end

  assign rsp_valid  = (state_q == FULL);
  assign rsp_result = rsp_result_q;
  assign rsp_src    = rsp_src_q;
  assign rsp_tag    = rsp_tag_q;
  assign cnt_a      = cnt_a_q;
  assign cnt_b      = cnt_b_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Testbench for alu_share_arbiter: directed vectors, expected responses
// queued at issue time and checked by an independent response monitor.
module tb_alu_share_arbiter;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned TAG_W  = 2;
  localparam int unsigned CNT_W  = 16;

  logic              clk;
  logic              rst_n;
  logic              a_valid, b_valid;
  logic              a_ready, b_ready;
  logic [2:0]        a_op_select, b_op_select;
  logic [DATA_W-1:0] a_op1, a_op2, b_op1, b_op2;
  logic              a_alt_operator, b_alt_operator;
  logic              a_branch_mode, b_branch_mode;
  logic [TAG_W-1:0]  a_tag, b_tag;
  logic [2:0]        alu_op_select;
  logic [DATA_W-1:0] alu_op1, alu_op2, alu_result;
  logic              alu_alt_operator, alu_branch_mode;
  logic              rsp_valid, rsp_ready, rsp_src;
  logic [DATA_W-1:0] rsp_result;
  logic [TAG_W-1:0]  rsp_tag;
  logic [CNT_W-1:0]  cnt_a, cnt_b;

  // second instance with 2-bit counters, sharing all request inputs
  logic              a_ready_s, b_ready_s;
  logic [2:0]        alu_op_select_s;
  logic [DATA_W-1:0] alu_op1_s, alu_op2_s, alu_result_s;
  logic              alu_alt_operator_s, alu_branch_mode_s;
  logic              rsp_valid_s, rsp_src_s;
  logic [DATA_W-1:0] rsp_result_s;
  logic [TAG_W-1:0]  rsp_tag_s;
  logic [1:0]        cnt_a_s, cnt_b_s;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [31:0] res;
    logic        src;
    logic [1:0]  tag;
  } exp_t;

  exp_t sb[$];

  alu_share_arbiter #(.DATA_W(DATA_W), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_op_select(a_op_select),
    .a_op1(a_op1), .a_op2(a_op2), .a_alt_operator(a_alt_operator),
    .a_branch_mode(a_branch_mode), .a_tag(a_tag),
    .b_valid(b_valid), .b_ready(b_ready), .b_op_select(b_op_select),
    .b_op1(b_op1), .b_op2(b_op2), .b_alt_operator(b_alt_operator),
    .b_branch_mode(b_branch_mode), .b_tag(b_tag),
    .alu_op_select(alu_op_select), .alu_op1(alu_op1), .alu_op2(alu_op2),
    .alu_alt_operator(alu_alt_operator), .alu_branch_mode(alu_branch_mode),
    .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_src(rsp_src), .rsp_tag(rsp_tag),
    .cnt_a(cnt_a), .cnt_b(cnt_b)
  );

  alu_share_arbiter #(.DATA_W(DATA_W), .TAG_W(TAG_W), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready_s), .a_op_select(a_op_select),
    .a_op1(a_op1), .a_op2(a_op2), .a_alt_operator(a_alt_operator),
    .a_branch_mode(a_branch_mode), .a_tag(a_tag),
    .b_valid(b_valid), .b_ready(b_ready_s), .b_op_select(b_op_select),
    .b_op1(b_op1), .b_op2(b_op2), .b_alt_operator(b_alt_operator),
    .b_branch_mode(b_branch_mode), .b_tag(b_tag),
    .alu_op_select(alu_op_select_s), .alu_op1(alu_op1_s), .alu_op2(alu_op2_s),
    .alu_alt_operator(alu_alt_operator_s), .alu_branch_mode(alu_branch_mode_s),
    .alu_result(alu_result_s),
    .rsp_valid(rsp_valid_s), .rsp_ready(rsp_ready), .rsp_result(rsp_result_s),
    .rsp_src(rsp_src_s), .rsp_tag(rsp_tag_s),
    .cnt_a(cnt_a_s), .cnt_b(cnt_b_s)
  );

  // Behavioural model of the attached combinational alu.
  function automatic logic [31:0] alu_f(input logic [2:0] op, input logic [31:0] x,
                                        input logic [31:0] y, input logic alt,
                                        input logic br);
    logic [31:0] r;
    r = '0;
    if (br) begin
      case (op)
        3'b000:  r = 32'(x == y);
        3'b001:  r = 32'(x != y);
        3'b100:  r = 32'($signed(x) < $signed(y));
        3'b101:  r = 32'($signed(x) >= $signed(y));
        3'b110:  r = 32'(x < y);
        3'b111:  r = 32'(x >= y);
        default: r = '0;
      endcase
    end else begin
      case (op)
        3'b000:  r = alt ? (x - y) : (x + y);
        3'b001:  r = x << y[4:0];
        3'b010:  r = 32'($signed(x) < $signed(y));
        3'b011:  r = 32'(x < y);
        3'b100:  r = x ^ y;
        3'b101:  r = alt ? 32'($signed(x) >>> y[4:0]) : (x >> y[4:0]);
        3'b110:  r = x | y;
        default: r = x & y;
      endcase
    end
    return r;
  endfunction

  assign alu_result   = alu_f(alu_op_select, alu_op1, alu_op2, alu_alt_operator, alu_branch_mode);
  assign alu_result_s = alu_f(alu_op_select_s, alu_op1_s, alu_op2_s, alu_alt_operator_s,
                              alu_branch_mode_s);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] res, input logic src, input logic [1:0] tag);
    exp_t e;
    e.res = res;
    e.src = src;
    e.tag = tag;
    sb.push_back(e);
  endtask

  // Response monitor: every transfer (valid & ready) must match the queue head.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rsp_unexpected actual=0x%0h required=no_response t=%0t",
                 rsp_result, $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_result", rsp_result, e.res);
        chk("rsp_src", 32'(rsp_src), 32'(e.src));
        chk("rsp_tag", 32'(rsp_tag), 32'(e.tag));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    rsp_ready = 1'b1;
    a_valid = 1'b1; a_op_select = 3'b000; a_op1 = '0; a_op2 = '0;
    a_alt_operator = 1'b0; a_branch_mode = 1'b0; a_tag = '0;
    b_valid = 1'b0; b_op_select = 3'b000; b_op1 = '0; b_op2 = '0;
    b_alt_operator = 1'b0; b_branch_mode = 1'b0; b_tag = '0;

    // reset state; a_valid held high must not produce a ready
    @(negedge clk);
    chk("rst_a_ready", 32'(a_ready), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_result", rsp_result, 0);
    chk("rst_rsp_src", 32'(rsp_src), 0);
    chk("rst_rsp_tag", 32'(rsp_tag), 0);
    chk("rst_cnt_a", 32'(cnt_a), 0);
    chk("rst_cnt_b", 32'(cnt_b), 0);
    #2;
    a_valid = 1'b0;
    rst_n = 1'b1;

    // A only: 5 + 3, tag 2
    tick();
    a_valid = 1'b1; a_op_select = 3'b000; a_op1 = 32'd5; a_op2 = 32'd3; a_tag = 2'd2;
    push(32'd8, 1'b0, 2'd2);
    @(negedge clk);
    chk("a1_a_ready", 32'(a_ready), 1);
    chk("a1_b_ready", 32'(b_ready), 0);
    chk("a1_alu_op1", alu_op1, 32'd5);
    chk("a1_alu_op2", alu_op2, 32'd3);
    tick();
    a_valid = 1'b0;
    @(negedge clk);
    chk("a1_rsp_valid", 32'(rsp_valid), 1);
    chk("a1_cnt_a", 32'(cnt_a), 1);
    chk("a1_cnt_b", 32'(cnt_b), 0);
    chk("a1_cnt_a_s", 32'(cnt_a_s), 1);
    // idle: alu inputs zeroed even though port A fields are still non-zero
    tick();
    @(negedge clk);
    chk("idle_rsp_valid", 32'(rsp_valid), 0);
    chk("idle_alu_op1", alu_op1, 0);
    chk("idle_alu_op2", alu_op2, 0);
    chk("idle_alu_op_sel", 32'(alu_op_select), 0);
    chk("idle_a_ready", 32'(a_ready), 0);
    chk("idle_b_ready", 32'(b_ready), 0);

    // backpressure: A xor accepted, then B blocked while rsp_ready low
    tick();
    rsp_ready = 1'b0;
    a_valid = 1'b1; a_op_select = 3'b100; a_op1 = 32'hF0; a_op2 = 32'h0F; a_tag = 2'd0;
    push(32'hFF, 1'b0, 2'd0);
    @(negedge clk);
    chk("bp_a_ready", 32'(a_ready), 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i == 0) begin
        a_valid = 1'b0;
        b_valid = 1'b1; b_op_select = 3'b110; b_op1 = 32'h3; b_op2 = 32'hC;
        b_alt_operator = 1'b0; b_branch_mode = 1'b0; b_tag = 2'd1;
        push(32'hF, 1'b1, 2'd1);
      end
      @(negedge clk);
      chk("bp_b_ready", 32'(b_ready), 0);
      chk("bp_rsp_valid", 32'(rsp_valid), 1);
      chk("bp_rsp_result", rsp_result, 32'hFF);
      chk("bp_rsp_src", 32'(rsp_src), 0);
    end
    tick();
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_b_ready", 32'(b_ready), 1);
    tick();
    b_valid = 1'b0;
    @(negedge clk);
    chk("bp_b_rsp_src", 32'(rsp_src), 1);
    chk("bp_b_rsp_valid", 32'(rsp_valid), 1);
    chk("bp_cnt_a", 32'(cnt_a), 2);
    chk("bp_cnt_b", 32'(cnt_b), 1);
    tick();
    @(negedge clk);
    chk("bp_drain_rsp_valid", 32'(rsp_valid), 0);

    // reset while FULL: buffer discarded, counters cleared asynchronously
    tick();
    rsp_ready = 1'b0;
    a_valid = 1'b1; a_op_select = 3'b000; a_op1 = 32'd1; a_op2 = 32'd1; a_tag = 2'd3;
    @(negedge clk);
    chk("mr_a_ready", 32'(a_ready), 1);
    tick();
    a_valid = 1'b0;
    @(negedge clk);
    chk("mr_full", 32'(rsp_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_rsp_valid", 32'(rsp_valid), 0);
    chk("mr_cnt_a", 32'(cnt_a), 0);
    chk("mr_cnt_b", 32'(cnt_b), 0);
    chk("mr_rsp_tag", 32'(rsp_tag), 0);
    @(negedge clk);
    rsp_ready = 1'b1;
    #2;
    rst_n = 1'b1;

    // contention after reset: A sub 10-4, B branch-eq 7,7 -> A,B,A,B
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 0) begin
        a_valid = 1'b1; a_op_select = 3'b000; a_op1 = 32'd10; a_op2 = 32'd4;
        a_alt_operator = 1'b1; a_branch_mode = 1'b0; a_tag = 2'd1;
        b_valid = 1'b1; b_op_select = 3'b000; b_op1 = 32'd7; b_op2 = 32'd7;
        b_alt_operator = 1'b0; b_branch_mode = 1'b1; b_tag = 2'd3;
      end
      if ((i % 2) == 0) push(32'd6, 1'b0, 2'd1);
      else              push(32'd1, 1'b1, 2'd3);
      @(negedge clk);
      chk("rr_a_ready", 32'(a_ready), 32'((i % 2) == 0));
      chk("rr_b_ready", 32'(b_ready), 32'((i % 2) == 1));
      chk("rr_alu_op1", alu_op1, ((i % 2) == 0) ? 32'd10 : 32'd7);
      if (i > 0) chk("rr_rsp_valid", 32'(rsp_valid), 1);
    end
    tick();
    a_valid = 1'b0; b_valid = 1'b0; a_alt_operator = 1'b0;
    @(negedge clk);
    chk("rr_last_rsp_valid", 32'(rsp_valid), 1);
    tick();
    @(negedge clk);
    chk("rr_drain_rsp_valid", 32'(rsp_valid), 0);
    chk("rr_cnt_a", 32'(cnt_a), 2);
    chk("rr_cnt_b", 32'(cnt_b), 2);

    // saturation: fresh reset, 5 back-to-back A grants (and 0xFF & i = i)
    #2;
    rst_n = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      a_valid = 1'b1; a_op_select = 3'b111; a_op1 = 32'hFF; a_op2 = 32'(i);
      a_tag = 2'(i);
      push(32'(i), 1'b0, 2'(i));
      @(negedge clk);
      chk("sat_a_ready", 32'(a_ready), 1);
      chk("sat_cnt_a_s", 32'(cnt_a_s), (i > 3) ? 32'd3 : 32'(i));
    end
    tick();
    a_valid = 1'b0;
    @(negedge clk);
    chk("sat_cnt_a", 32'(cnt_a), 5);
    chk("sat_cnt_b", 32'(cnt_b), 0);
    chk("sat_cnt_a_s_final", 32'(cnt_a_s), 3);
    chk("sat_cnt_b_s_final", 32'(cnt_b_s), 0);
    tick();
    @(negedge clk);
    chk("sat_drain_rsp_valid", 32'(rsp_valid), 0);
    chk("sb_drained", 32'(sb.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
Shares the single combinational alu between two requesters: port A (execute stage) and port B (branch-compare unit).
- Arbitrates round-robin with valid/ready handshakes.
- Drives the alu inputs from the granted request.
- Registers the alu result into a one-entry response buffer with valid/ready backpressure.
- Keeps per-port saturating grant counters for performance debug.

Parameters:
DATA_W, 32, operand/result width (alu is fixed at 32; only 32 is supported)
TAG_W, 2, width of the requester-supplied tag returned with each result
CNT_W, 16, width of each saturating grant counter

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
a_valid  input  1  port A request valid
a_ready  output  1  port A request accepted this cycle
a_op_select  input  3  port A alu op select
a_op1  input  DATA_W  port A operand 1
a_op2  input  DATA_W  port A operand 2
a_alt_operator  input  1  port A alt operator (sub/arith shift)
a_branch_mode  input  1  port A branch compare mode
a_tag  input  TAG_W  port A tag
b_valid, b_ready, b_op_select, b_op1, b_op2, b_alt_operator, b_branch_mode, b_tag  same directions/widths as the port A set, for port B
alu_op_select  output  3  to alu
alu_op1  output  DATA_W  to alu
alu_op2  output  DATA_W  to alu
alu_alt_operator  output  1  to alu
alu_branch_mode  output  1  to alu
alu_result  input  DATA_W  from alu, combinational in the same cycle
rsp_valid  output  1  response buffer holds a result
rsp_ready  input  1  consumer accepts the response
rsp_result  output  DATA_W  registered alu result
rsp_src  output  1  0 = port A, 1 = port B
rsp_tag  output  TAG_W  tag of the originating request
cnt_a  output  CNT_W  saturating count of port A grants
cnt_b  output  CNT_W  saturating count of port B grants

Behaviour:
- Reset (async assert, sync-safe release):
  - state = EMPTY, rsp_valid = 0, rsp_result = 0, rsp_src = 0, rsp_tag = 0.
  - last_grant = 1, so A wins the first contention.
  - cnt_a = cnt_b = 0.
- States:
  - EMPTY: buffer free.
  - FULL: buffer holds an undelivered result.
- slot_free = (state == EMPTY) | (state == FULL & rsp_ready).
- Grant, combinational:
  - If !slot_free, no grant.
  - If only one port is valid, grant that port.
  - If both are valid, grant the port != last_grant.
- Ready outputs: a_ready = grant_a, b_ready = grant_b. At most one is high per cycle, and neither is high without its valid.
- alu inputs:
  - With a grant, they carry the granted port's fields.
  - With no grant, all are driven to 0.
  - They are never left floating or latched.
- On a clock edge with a grant:
  - rsp_result <= alu_result, rsp_src <= granted port, rsp_tag <= granted tag.
  - rsp_valid <= 1, state -> FULL, last_grant <= granted port.
- On a clock edge without a grant:
  - If state == FULL & rsp_ready: rsp_valid <= 0, state -> EMPTY.
  - Otherwise hold all registers.
- Latency and throughput:
  - Request accepted in cycle N gives rsp_valid in cycle N+1.
  - Sustained one result per cycle while rsp_ready = 1.
- Simultaneous drain and accept in FULL (rsp_ready = 1 and a grant): the buffer is overwritten with the new result and rsp_valid stays 1. No bubble and no loss.
- Backpressure (FULL & !rsp_ready):
  - Both readys = 0.
  - rsp_* outputs hold stable.
  - Requesters must hold their fields stable while valid & !ready.
- last_grant changes only on a grant. A lone requester may be granted back-to-back indefinitely.
- Counters: cnt_x increments on each grant of port x and saturates at 2^CNT_W-1 (no wrap).
- Reset mid-operation: any buffered result is discarded. No ready asserts while rst_n = 0.

Test Plan:
- Reset, then A only: op_select 000, op1 5, op2 3, alt 0, tag 2 -> a_ready = 1 in cycle 0; cycle 1: rsp_valid = 1, rsp_result = 8, rsp_src = 0, rsp_tag = 2; cnt_a = 1.
- Both valid every cycle, rsp_ready = 1, A = sub 10-4, B = branch 000 with 7,7 -> grants A,B,A,B; results 6,1,6,1 alternating rsp_src 0,1,0,1; one result per cycle.
- Backpressure: A accepted (xor 0xF0,0x0F), rsp_ready = 0 for 3 cycles while B valid -> b_ready = 0 throughout, rsp_result = 0xFF held; rsp_ready = 1 -> B granted that cycle, next cycle rsp_src = 1.
- Idle: no valids -> alu_op1/op2/op_select = 0, both readys = 0; rsp_valid drops 1 cycle after the last drain.
- Reset mid-stream: rst_n low while FULL -> rsp_valid = 0 immediately (async), counters = 0; after release, contention grants A first.
- Saturation: CNT_W = 2, 5 A grants -> cnt_a = 3, cnt_b = 0.
